tx_serializer_10b: RTL and testbench

Parallel-to-serial stage directly downstream of `encoder_8b10b`. It accepts 10-bit encoded symbols on a valid/ready handshake and shifts each one out one bit per clock on `serial_o`, keeping 10-bit symbol framing. When no symbol is ready at a symbol boundary, it inserts an all-zero electrical-idle slot. It feeds the TX analog/PAD model of the PCIe physical layer.

---
 rtl/pcie_phy_pkg.sv | 18 +
 rtl/tx_serializer_10b.sv | 141 ++++++++++++++
 tb/tb_tx_serializer_10b.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: symbol width and type, K28.5 comma
// encodings and the serializer FSM states.
package pcie_phy_pkg;

  localparam int unsigned SYMBOL_W = 10;

  typedef logic [9:0] symbol_t;

  // abcdei fghj with bit a at bit 0
  localparam symbol_t K28_5_RDN = 10'h17C;
  localparam symbol_t K28_5_RDP = 10'h283;

  typedef enum logic {
    IDLE,
    ACTIVE
  } tx_ser_state_e;

endpackage

// File: rtl/tx_serializer_10b.sv
// 10-bit symbol serializer with a 1-entry holding register and idle-slot insertion.
// Optional saturating symbol/underrun counters are built when TX_SER_STATS_EN is defined.
module tx_serializer_10b #(
  parameter int unsigned SYMBOL_W  = 10,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned STAT_W    = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                enable_i,
  input  logic [SYMBOL_W-1:0] symbol_i,
  input  logic                symbol_valid_i,
  output logic                symbol_ready_o,
  output logic                serial_o,
  output logic                symbol_start_o,
  output logic                tx_active_o,
  output logic                underrun_o
`ifdef TX_SER_STATS_EN
  ,
  output logic [STAT_W-1:0]   sym_count_o,
  output logic [STAT_W-1:0]   underrun_count_o
`endif
);
  import pcie_phy_pkg::*;

  if (SYMBOL_W != 10 || STAT_W == 0) begin : g_bad_cfg
    $error("tx_serializer_10b supports only SYMBOL_W=10 and STAT_W>0");
  end

  localparam logic [3:0] LAST_BIT = 4'(SYMBOL_W - 1);

  tx_ser_state_e       state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [SYMBOL_W-1:0] shift_q, shift_d;
  logic [SYMBOL_W-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                serial_q, serial_d;
  logic                start_q, start_d;
  logic                underrun_q, underrun_d;
  logic                load_now;
  logic                accept;
  logic [SYMBOL_W-1:0] load_val;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    serial_d    = 1'b0;
    start_d     = 1'b0;
    underrun_d  = 1'b0;

    accept   = symbol_valid_i & ~hold_full_q;
    load_now = ((state_q == IDLE) & enable_i & hold_full_q) |
               ((state_q == ACTIVE) & (bit_cnt_q == LAST_BIT) & enable_i);
    load_val = hold_full_q ? hold_q : '0;

    // shift_q only ever holds the bits still to be sent after serial_q
    if (load_now) begin
      state_d    = ACTIVE;
      bit_cnt_d  = '0;
      serial_d   = LSB_FIRST ? load_val[0] : load_val[SYMBOL_W-1];
      shift_d    = LSB_FIRST ? (load_val >> 1) : (load_val << 1);
      start_d    = 1'b1;
      underrun_d = ~hold_full_q;
      if (hold_full_q) hold_full_d = 1'b0;
    end else if (state_q == ACTIVE) begin
      if (bit_cnt_q == LAST_BIT) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        serial_d  = LSB_FIRST ? shift_q[0] : shift_q[SYMBOL_W-1];
        shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
      end
    end

    // accept only happens with hold empty, so it never collides with a hold consume
    if (accept) begin
      hold_d      = symbol_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      serial_q    <= 1'b0;
      start_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      serial_q    <= serial_d;
      start_q     <= start_d;
      underrun_q  <= underrun_d;
    end
  end

  assign symbol_ready_o = ~hold_full_q;
  assign serial_o       = serial_q;
  assign symbol_start_o = start_q;
  assign tx_active_o    = (state_q == ACTIVE);
  assign underrun_o     = underrun_q;

`ifdef TX_SER_STATS_EN
  logic [STAT_W-1:0] sym_count_q, sym_count_d;
  logic [STAT_W-1:0] underrun_count_q, underrun_count_d;

  always_comb begin
    sym_count_d      = sym_count_q;
    underrun_count_d = underrun_count_q;
    if (load_now & hold_full_q & ~(&sym_count_q))
      sym_count_d = sym_count_q + STAT_W'(1);
    if (load_now & ~hold_full_q & ~(&underrun_count_q))
      underrun_count_d = underrun_count_q + STAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sym_count_q      <= '0;
      underrun_count_q <= '0;
    end else begin
      sym_count_q      <= sym_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign sym_count_o      = sym_count_q;
  assign underrun_count_o = underrun_count_q;
`endif

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Bench for tx_serializer_10b: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a slot-level reference model (counters when TX_SER_STATS_EN).
module tb_tx_serializer_10b;
  import pcie_phy_pkg::*;

  logic       clk_i          = 1'b0;
  logic       reset_ni       = 1'b1;
  logic       enable_i       = 1'b0;
  logic [9:0] symbol_i       = '0;
  logic       symbol_valid_i = 1'b0;

  logic ready_a, serial_a, start_a, active_a, under_a;
  logic ready_b, serial_b, start_b, active_b, under_b;
`ifdef TX_SER_STATS_EN
  logic [15:0] symcnt_a, udrcnt_a, symcnt_b, udrcnt_b;
`endif

  always #5 clk_i = ~clk_i;

  tx_serializer_10b #(.SYMBOL_W(10), .LSB_FIRST(1'b1), .STAT_W(16)) u_dut_lsb (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i),
    .symbol_i(symbol_i), .symbol_valid_i(symbol_valid_i), .symbol_ready_o(ready_a),
    .serial_o(serial_a), .symbol_start_o(start_a), .tx_active_o(active_a),
    .underrun_o(under_a)
`ifdef TX_SER_STATS_EN
    , .sym_count_o(symcnt_a), .underrun_count_o(udrcnt_a)
`endif
  );

  tx_serializer_10b #(.SYMBOL_W(10), .LSB_FIRST(1'b0), .STAT_W(16)) u_dut_msb (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i),
    .symbol_i(symbol_i), .symbol_valid_i(symbol_valid_i), .symbol_ready_o(ready_b),
    .serial_o(serial_b), .symbol_start_o(start_b), .tx_active_o(active_b),
    .underrun_o(under_b)
`ifdef TX_SER_STATS_EN
    , .sym_count_o(symcnt_b), .underrun_count_o(udrcnt_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: the slot currently on the wire (symbol + bit index) and a pending queue.
  logic [9:0] m_hold[$];
  logic [9:0] tx_q[$];
  bit         m_active, m_start, m_under;
  logic [9:0] m_sym;
  int         m_idx, m_nsym, m_nund;

  task automatic model_clear();
    m_hold.delete();
    m_active = 1'b0; m_start = 1'b0; m_under = 1'b0;
    m_sym = '0; m_idx = 0; m_nsym = 0; m_nund = 0;
  endtask

  task automatic model_step(input bit en, input bit vld, input logic [9:0] sym, output bit acc);
    acc = vld && (m_hold.size() == 0);
    m_start = 1'b0;
    m_under = 1'b0;
    if (!m_active || m_idx == 9) begin
      if (en && (m_active || m_hold.size() > 0)) begin
        m_active = 1'b1;
        m_idx    = 0;
        m_start  = 1'b1;
        if (m_hold.size() > 0) begin
          m_sym = m_hold.pop_front();
          m_nsym++;
        end else begin
          m_sym   = '0;
          m_under = 1'b1;
          m_nund++;
        end
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_idx++;
    end
    if (acc) m_hold.push_back(sym);
  endtask

  task automatic check_outputs();
    logic exp_a, exp_b;
    exp_a = m_active ? m_sym[m_idx] : 1'b0;
    exp_b = m_active ? m_sym[9 - m_idx] : 1'b0;
    check("serial_lsb", 32'(serial_a), 32'(exp_a));
    check("serial_msb", 32'(serial_b), 32'(exp_b));
    check("start", 32'({start_a, start_b}), 32'({m_start, m_start}));
    check("underrun", 32'({under_a, under_b}), 32'({m_under, m_under}));
    check("active", 32'({active_a, active_b}), 32'({m_active, m_active}));
    check("ready", 32'({ready_a, ready_b}), {30'd0, {2{m_hold.size() == 0}}});
`ifdef TX_SER_STATS_EN
    check("sym_count", 32'(symcnt_a), 32'(m_nsym));
    check("underrun_count", 32'(udrcnt_b), 32'(m_nund));
`endif
  endtask

  // Called at posedge+1: drive inputs, advance one clock, check the registered outputs.
  task automatic step(input bit en, input bit vld_gate);
    bit acc;
    enable_i       = en;
    symbol_valid_i = vld_gate && (tx_q.size() > 0);
    symbol_i       = (tx_q.size() > 0) ? tx_q[0] : 10'h000;
    model_step(en, symbol_valid_i, symbol_i, acc);
    @(posedge clk_i);
    if (acc) void'(tx_q.pop_front());
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, 32'({serial_a, start_a, active_a, under_a, ready_a,
                    serial_b, start_b, active_b, under_b, ready_b}), 32'b00001_00001);
`ifdef TX_SER_STATS_EN
    check({tag, "_cnt"}, {symcnt_a, udrcnt_a}, 32'd0);
`endif
  endtask

  // Asynchronous reset asserted between clock edges, held across two edges, released off-edge.
  task automatic async_reset_mid();
    #2;
    reset_ni = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_clear();
    tx_q.delete();
    enable_i       = 1'b0;
    symbol_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
  endtask

  initial begin
    logic [9:0] cap_a, cap_b;
    int n_ur, n_st;

    model_clear();
    #1 reset_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_values("reset");
    reset_ni = 1'b1;

    // Single K28.5 symbol: bit pattern on both bit orders
    tx_q.push_back(K28_5_RDN);
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      cap_a[i] = serial_a;
      cap_b[i] = serial_b;
    end
    check("k28_lsb_bits", 32'(cap_a), 32'h17C);
    check("k28_msb_bits", 32'(cap_b), 32'h0FA);
    repeat (2) step(1'b0, 1'b0);

    // Back-to-back stream: 30 contiguous bits, no idle slots
    tx_q.push_back(K28_5_RDN);
    tx_q.push_back(K28_5_RDP);
    tx_q.push_back(K28_5_RDN);
    n_ur = 0; n_st = 0;
    for (int i = 0; i < 31; i++) begin
      step(1'b1, 1'b1);
      n_ur += int'(under_a);
      n_st += int'(start_a);
    end
    check("stream_underruns", 32'(n_ur), 32'd0);
    check("stream_starts", 32'(n_st), 32'd3);
    repeat (2) step(1'b0, 1'b0);

    // Late second symbol: exactly one idle slot before it
    tx_q.push_back(10'h2A5);
    step(1'b1, 1'b1);
    n_ur = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0);
      n_ur += int'(under_a);
    end
    tx_q.push_back(10'h15A);
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b1);
      n_ur += int'(under_a);
    end
    check("late_underruns", 32'(n_ur), 32'd1);
    repeat (2) step(1'b0, 1'b0);

    // Enable dropped at bit 4: symbol completes, held symbol sent after re-enable
    tx_q.push_back(10'h3C1);
    tx_q.push_back(10'h0E7);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Reset at bit 6 with a symbol also waiting in hold
    tx_q.push_back(10'h1F0);
    tx_q.push_back(10'h30F);
    step(1'b1, 1'b1);
    repeat (7) step(1'b1, 1'b1);
    async_reset_mid();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if (tx_q.size() < 2 && ($urandom % 3) == 0) tx_q.push_back(10'($urandom));
      step(($urandom % 16) != 0, ($urandom % 4) != 0);
      if (i % 700 == 699) async_reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
